// File: rtl/tlul_pkg.sv
`timescale 1ns/1ps
// tlul_pkg
// Purpose: TL-UL channel structures and opcode encodings shared by the
//          adapter and its bench. Widths: TL_AW=32, TL_DW=32, TL_DBW=4.
// Contents: tl_h2d_t (host->device A channel plus d_ready),
//           tl_d2h_t (device->host D channel plus a_ready),
//           A-channel and D-channel opcode enums.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Opcode fields are plain vectors so that illegal opcodes can be carried.
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_adapter_mem.sv
`timescale 1ns/1ps
// tlul_adapter_mem
// Purpose: TL-UL device-side adapter turning each A-channel request into a
//          single word-wide req/gnt/rvalid memory access, one transaction
//          outstanding at a time. Placed in front of an SRAM or register file.
// Optional feature: define TLUL_MEM_ERR_CHECK_EN to reject malformed
//          requests (bad opcode, size, alignment, range or mask) with an
//          error response and no memory access. Without it every request is
//          forwarded and any opcode other than PutFull/PutPartial is a Get.
// Ports:
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   tl_i / tl_o         TL-UL host->device / device->host
//   req_o, gnt_i        memory request, held until granted
//   we_o, addr_o        write enable, word address
//   wdata_o, wmask_o    write data, bit-level write mask (0 for reads)
//   rvalid_i, rdata_i   read return and its data
//   rerror_i            read error, qualified by rvalid_i
//   busy_o              high whenever a transaction is in flight
module tlul_adapter_mem
  import tlul_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [MEM_AW-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  input  logic              rerror_i,
  output logic              busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  // Counter only needs to reach RSP_TIMEOUT-1.
  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             put_q;

  logic             d_valid;
  logic [2:0]       d_opcode;
  logic [1:0]       d_size;
  logic [7:0]       d_source;
  logic [31:0]      d_data;
  logic             d_error;

  logic             a_put;
  logic             chk_err;
  logic [31:0]      mask_bits;

  assign a_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);

  // Each byte-enable bit widens to a full byte lane of the bit mask.
  always_comb begin
    mask_bits = '0;
    for (int i = 0; i < 4; i++) begin
      mask_bits[8*i +: 8] = {8{tl_i.a_mask[i]}};
    end
  end

`ifdef TLUL_MEM_ERR_CHECK_EN
  logic [3:0] lanes;
  logic       misaligned;

  // Byte lanes covered by the request; size 3 is flagged via misaligned.
  always_comb begin
    lanes      = 4'h0;
    misaligned = 1'b0;
    case (tl_i.a_size)
      2'd0: lanes = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        lanes      = 4'b0011 << {tl_i.a_address[1], 1'b0};
        misaligned = tl_i.a_address[0];
      end
      2'd2: begin
        lanes      = 4'hF;
        misaligned = |tl_i.a_address[1:0];
      end
      default: begin
        lanes      = 4'h0;
        misaligned = 1'b1;
      end
    endcase
  end

  assign chk_err = !(a_put || (tl_i.a_opcode == Get))
                || misaligned
                || ((tl_i.a_address >> (MEM_AW + 2)) != '0)
                || (|(tl_i.a_mask & ~lanes))
                || ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != lanes));
`else
  assign chk_err = 1'b0;
`endif

  // Fields that carry no meaning for this adapter.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address};

  // Main transaction FSM; every memory and D-channel output is a register
  // loaded here so nothing downstream sees combinational paths from tl_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      count    <= '0;
      put_q    <= 1'b0;
      req_o    <= 1'b0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      wmask_o  <= '0;
      d_valid  <= 1'b0;
      d_opcode <= 3'h0;
      d_size   <= 2'h0;
      d_source <= 8'h0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tl_i.a_valid) begin
            put_q    <= a_put;
            d_opcode <= a_put ? AccessAck : AccessAckData;
            d_size   <= tl_i.a_size;
            d_source <= tl_i.a_source;
            d_data   <= '0;
            we_o     <= a_put;
            addr_o   <= tl_i.a_address[MEM_AW+1:2];
            wdata_o  <= tl_i.a_data;
            wmask_o  <= a_put ? mask_bits : '0;
            if (chk_err) begin
              d_error <= 1'b1;
              d_valid <= 1'b1;
              state   <= RSP;
            end else begin
              d_error <= 1'b0;
              req_o   <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            if (put_q) begin
              d_valid <= 1'b1;
              state   <= RSP;
            end else begin
              count <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A response in the timeout cycle still wins.
          if (rvalid_i) begin
            d_data  <= rerror_i ? '0 : rdata_i;
            d_error <= rerror_i;
            d_valid <= 1'b1;
            state   <= RSP;
          end else if ((RSP_TIMEOUT != 0) && (count == CNT_LAST)) begin
            d_data  <= '0;
            d_error <= 1'b1;
            d_valid <= 1'b1;
            state   <= RSP;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RSP: begin
          if (tl_i.d_ready) begin
            d_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = d_opcode;
    tl_o.d_size   = d_size;
    tl_o.d_source = d_source;
    tl_o.d_data   = d_data;
    tl_o.d_error  = d_error;
    tl_o.a_ready  = (state == IDLE);
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_tlul_adapter_mem.sv
`timescale 1ns/1ps
// tb_tlul_adapter_mem
// Purpose: self-checking bench for tlul_adapter_mem. A byte-level reference
//          memory predicts read data, a separate memory responder applies the
//          DUT's own write mask, and expected latencies and D-channel fields
//          come from the transaction rules. Works with or without
//          TLUL_MEM_ERR_CHECK_EN.
module tb_tlul_adapter_mem;
  import tlul_pkg::*;

  localparam int MEM_AW      = 16;
  localparam int RSP_TIMEOUT = 4;
`ifdef TLUL_MEM_ERR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic              req_o, gnt_i, we_o;
  logic [MEM_AW-1:0] addr_o;
  logic [31:0]       wdata_o, wmask_o;
  logic              rvalid_i;
  logic [31:0]       rdata_i;
  logic              rerror_i;
  logic              busy_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem  [int];
  logic [31:0] phys_mem [int];

  always #5 clk_i = ~clk_i;

  tlul_adapter_mem #(.MEM_AW(MEM_AW), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .tl_i    (tl_i),
    .tl_o    (tl_o),
    .req_o   (req_o),
    .gnt_i   (gnt_i),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .wmask_o (wmask_o),
    .rvalid_i(rvalid_i),
    .rdata_i (rdata_i),
    .rerror_i(rerror_i),
    .busy_o  (busy_o)
  );

  function automatic logic [31:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] phys_rd(input int k);
    return phys_mem.exists(k) ? phys_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) r = r | (32'hFF << (8 * i));
    return r;
  endfunction

  // Request legality rules stated as plain arithmetic on byte counts.
  function automatic bit ref_check_err(input logic [2:0] op, input logic [31:0] addr,
                                       input logic [1:0] size, input logic [3:0] mask);
    int nbytes, off, lanes;
    bit bad;
    nbytes = 1 << size;
    off    = int'(addr % 32'd4);
    lanes  = ((1 << nbytes) - 1) << off;
    bad    = 1'b0;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) bad = 1'b1;
    if (size > 2'd2) bad = 1'b1;
    if ((addr % 32'(nbytes)) != 32'd0) bad = 1'b1;
    if (longint'(addr) >= (longint'(1) << (MEM_AW + 2))) bad = 1'b1;
    if ((int'(mask) & ~lanes) != 0) bad = 1'b1;
    if (op == 3'd0 && int'(mask) != lanes) bad = 1'b1;
    return CHECK_EN && bad;
  endfunction

  task automatic run_txn(input string name, input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] size, input logic [3:0] mask, input logic [31:0] data,
                         input logic [7:0] src, input int gnt_wait, input int rv_wait,
                         input logic rerr, input int stall);
    bit is_put, err, access, tmo, done, seen_req, granted, busy_ok;
    int word, exp_lat, cyc, req_cycles, wait_cycles;
    logic [MEM_AW-1:0] exp_addr;
    logic [31:0] exp_mask, exp_data, cur;
    logic [50:0] exp_vec, got_vec;

    is_put   = (op == 3'd0 || op == 3'd1);
    err      = ref_check_err(op, addr, size, mask);
    access   = !err;
    tmo      = access && !is_put && (rv_wait < 1 || rv_wait > RSP_TIMEOUT);
    word     = int'((addr >> 2) & ((32'h1 << MEM_AW) - 1));
    exp_addr = MEM_AW'(word);
    exp_mask = is_put ? expand(mask) : 32'h0;
    exp_data = (access && !is_put && !rerr && !tmo) ? ref_rd(word) : 32'h0;
    if (access && is_put) begin
      cur = ref_rd(word);
      for (int i = 0; i < 4; i++) if (mask[i]) cur[8*i +: 8] = data[8*i +: 8];
      ref_mem[word] = cur;
    end
    if (err)         exp_lat = 0;
    else if (is_put) exp_lat = 1 + gnt_wait;
    else if (tmo)    exp_lat = 1 + gnt_wait + RSP_TIMEOUT;
    else             exp_lat = 1 + gnt_wait + rv_wait;
    exp_vec = {1'b1, (is_put ? 3'd0 : 3'd1), 3'd0, size, src, 1'b0, exp_data,
               (err || (!is_put && (rerr || tmo)))};

    @(negedge clk_i);
    checks++;
    if (tl_o.a_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s a_ready_idle got=%0b want=1", name, tl_o.a_ready);
    end
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;

    cyc = 0; req_cycles = 0; wait_cycles = 0;
    done = 0; seen_req = 0; granted = 0; busy_ok = 1;
    while (!done && cyc < 100) begin
      gnt_i = 1'b0;
      rvalid_i = 1'b0;
      if (busy_o !== 1'b1) busy_ok = 0;
      if (tl_o.d_valid === 1'b1) begin
        checks++;
        if (cyc != exp_lat) begin
          failures++;
          $display("[TB] FAIL %s latency got=%0d want=%0d", name, cyc, exp_lat);
        end
        for (int k = 0; k <= stall; k++) begin
          got_vec = {tl_o.d_valid, tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source,
                     tl_o.d_sink, tl_o.d_data, tl_o.d_error};
          checks++;
          if (got_vec !== exp_vec || tl_o.a_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s d_fields[%0d] got=%h a_ready=%0b want=%h a_ready=0",
                     name, k, got_vec, tl_o.a_ready, exp_vec);
          end
          if (k < stall) @(negedge clk_i);
          else begin
            tl_i.d_ready = 1'b1;
            @(negedge clk_i);
            tl_i.d_ready = 1'b0;
          end
        end
        checks++;
        if ({tl_o.a_ready, busy_o, tl_o.d_valid} !== 3'b100) begin
          failures++;
          $display("[TB] FAIL %s after_d a_ready/busy/d_valid got=%b want=100", name,
                   {tl_o.a_ready, busy_o, tl_o.d_valid});
        end
        done = 1;
      end else if (req_o === 1'b1) begin
        seen_req = 1;
        checks++;
        if ({we_o, addr_o, wmask_o} !== {is_put, exp_addr, exp_mask} ||
            (is_put && wdata_o !== data)) begin
          failures++;
          $display("[TB] FAIL %s mem_req we/addr/wmask/wdata got=%0b/%h/%h/%h want=%0b/%h/%h/%h",
                   name, we_o, addr_o, wmask_o, wdata_o, is_put, exp_addr, exp_mask, data);
        end
        if (req_cycles == gnt_wait) begin
          gnt_i = 1'b1;
          granted = 1;
          if (we_o) phys_mem[int'(addr_o)] = (phys_rd(int'(addr_o)) & ~wmask_o) | (wdata_o & wmask_o);
        end
        req_cycles++;
      end else if (granted) begin
        wait_cycles++;
        if (wait_cycles == rv_wait) begin
          rvalid_i = 1'b1;
          rerror_i = rerr;
          rdata_i  = rerr ? $urandom : phys_rd(int'(addr_o));
        end
      end
      if (!done) begin
        @(negedge clk_i);
        cyc++;
      end
    end
    gnt_i = 1'b0;
    rvalid_i = 1'b0;
    rerror_i = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s no_response got=timeout want=d_valid", name);
    end else if (seen_req != access || !busy_ok) begin
      failures++;
      $display("[TB] FAIL %s req_seen/busy got=%0b/%0b want=%0b/1", name, seen_req, busy_ok, access);
    end
  endtask

  task automatic test_reset();
    tl_d2h_t exp_tl;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    exp_tl = '0;
    exp_tl.a_ready = 1'b1;
    checks++;
    if (tl_o !== exp_tl || {req_o, we_o, busy_o} !== 3'b000 ||
        addr_o !== '0 || wdata_o !== 32'h0 || wmask_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset tl_o=%h req/we/busy=%b addr=%h wdata=%h wmask=%h want tl_o=%h zeros",
               tl_o, {req_o, we_o, busy_o}, addr_o, wdata_o, wmask_o, exp_tl);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_put_full();
    run_txn("put_full", 3'd0, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'h5A, 0, 0, 1'b0, 0);
  endtask

  task automatic test_get_stall();
    run_txn("get_stall", 3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'h21, 2, 3, 1'b0, 0);
  endtask

  task automatic test_put_partial();
    run_txn("put_partial", 3'd1, 32'h12, 2'd0, 4'b0100, 32'h00AB0000, 8'h07, 0, 0, 1'b0, 0);
    run_txn("get_after_partial", 3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'h08, 0, 1, 1'b0, 0);
  endtask

  task automatic test_err_check();
`ifdef TLUL_MEM_ERR_CHECK_EN
    run_txn("err_unaligned", 3'd4, 32'h11, 2'd2, 4'hF, 32'h0, 8'h44, 0, 1, 1'b0, 0);
    run_txn("err_range", 3'd0, 32'h0004_0000, 2'd2, 4'hF, 32'h1, 8'h45, 0, 0, 1'b0, 0);
    run_txn("err_opcode", 3'd2, 32'h20, 2'd2, 4'hF, 32'h1, 8'h46, 0, 0, 1'b0, 0);
`else
    run_txn("odd_opcode_as_get", 3'd2, 32'h10, 2'd2, 4'hF, 32'h0, 8'h46, 0, 2, 1'b0, 0);
`endif
  endtask

  task automatic test_timeout();
    run_txn("timeout", 3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'h99, 1, 0, 1'b0, 0);
    run_txn("rvalid_at_timeout", 3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'h9A, 0, RSP_TIMEOUT, 1'b0, 0);
    run_txn("read_error", 3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'h9B, 0, 2, 1'b1, 0);
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      gnt_i = 1'b1;
      rvalid_i = 1'b1;
      rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      checks++;
      if ({req_o, busy_o, tl_o.d_valid, tl_o.a_ready} !== 4'b0001) begin
        failures++;
        $display("[TB] FAIL ignored_inputs req/busy/d_valid/a_ready got=%b want=0001",
                 {req_o, busy_o, tl_o.d_valid, tl_o.a_ready});
      end
    end
    gnt_i = 1'b0;
    rvalid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_put0", 3'd0, 32'h40, 2'd2, 4'hF, 32'h1234_5678, 8'h01, 0, 0, 1'b0, 0);
    run_txn("b2b_put1", 3'd1, 32'h44, 2'd1, 4'b1100, 32'hCAFE_0000, 8'h02, 1, 0, 1'b0, 0);
    run_txn("b2b_get0", 3'd4, 32'h40, 2'd2, 4'hF, 32'h0, 8'h03, 0, 1, 1'b0, 0);
    run_txn("b2b_get1", 3'd4, 32'h44, 2'd2, 4'hF, 32'h0, 8'h04, 0, 1, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] size;
    logic [3:0] mask, lanes;
    logic [31:0] addr;
    int sel, off;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      op = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd4 : 3'($urandom_range(2, 7));
      size = 2'($urandom_range(0, 2));
      off = (size == 2'd0) ? int'($urandom_range(0, 3)) : (size == 2'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
      addr = 32'($urandom_range(0, 15)) * 32'd4 + 32'(off);
      if ($urandom_range(0, 9) == 0) addr = addr | 32'h0010_0000;
      lanes = 4'(((1 << (1 << size)) - 1) << off);
      mask = (op == 3'd1) ? (lanes & 4'($urandom)) : lanes;
      if (mask == 4'h0) mask = lanes;
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
      run_txn($sformatf("rand%0d", n), op, addr, size, mask, $urandom, 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(1, RSP_TIMEOUT + 1)),
              1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_dready_stall_and_reset();
    run_txn("dready_stall", 3'd0, 32'h30, 2'd2, 4'hF, 32'h0BAD_F00D, 8'h77, 0, 0, 1'b0, 5);
    @(negedge clk_i);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = 3'd4;
    tl_i.a_size    = 2'd2;
    tl_i.a_address = 32'h30;
    tl_i.a_mask    = 4'hF;
    tl_i.a_source  = 8'h33;
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    checks++;
    if (req_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_wait req_before_grant got=%0b want=1", req_o);
    end
    gnt_i = 1'b1;
    @(negedge clk_i);
    gnt_i = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({req_o, tl_o.a_ready, busy_o, tl_o.d_valid} !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL rst_mid_wait req/a_ready/busy/d_valid got=%b want=0100",
               {req_o, tl_o.a_ready, busy_o, tl_o.d_valid});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({tl_o.a_ready, busy_o} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rst_release a_ready/busy got=%b want=10", {tl_o.a_ready, busy_o});
    end
  endtask

  initial begin
    tl_i     = '0;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    rerror_i = 1'b0;
    rst_ni   = 1'b0;
    test_reset();
    test_put_full();
    test_get_stall();
    test_put_partial();
    test_err_check();
    test_timeout();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    test_dready_stall_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
